error_calculation: RTL and testbench

Tracks the best candidate solution seen so far in the neural-network nonlinear-equation solver. Each candidate's weight vector arrives over one or more clock cycles, together with its residual error. The block keeps the candidate whose error has the smallest magnitude and presents that weight vector and error as registered outputs. It sits after the error-evaluation datapath and feeds the result and convergence logic.

---
 rtl/error_calculation_pkg.sv | 18 +
 rtl/error_calculation_mag_less.sv | 33 +++
 rtl/error_calculation.sv | 87 ++++++++
 tb/tb_error_calculation.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/error_calculation_pkg.sv
// Shared definitions for the best-candidate tracker: exception-class
// encoding of the 34-bit word, word width and the +infinity word.
package error_calculation_pkg;

  localparam int ELEMENT_WIDTH_DEF = 32;
  localparam int EXTRA_DEF         = 2;
  localparam int W                 = EXTRA_DEF + ELEMENT_WIDTH_DEF;

  // Exception class prefix. The encoding doubles as the magnitude rank:
  // zero < normal < infinity, with NaN sorting above everything.
  localparam logic [1:0] EXN_ZERO   = 2'b00;
  localparam logic [1:0] EXN_NORMAL = 2'b01;
  localparam logic [1:0] EXN_INF    = 2'b10;
  localparam logic [1:0] EXN_NAN    = 2'b11;

  localparam logic [W-1:0] POS_INF = {EXN_INF, 32'h7F80_0000};

endpackage

// File: rtl/error_calculation_mag_less.sv
// fp_mag_less: combinational |a| < |b| for the {exn, sign, exp, frac} word.
// Sign is ignored; classes order zero < normal < inf (< NaN); only two
// normals look at {exp, frac}. Equal magnitudes return 0.
module fp_mag_less
  import error_calculation_pkg::*;
#(
  parameter int ELEMENT_WIDTH = 32,
  parameter int Extra         = 2
) (
  input  logic [Extra+ELEMENT_WIDTH-1:0] a,
  input  logic [Extra+ELEMENT_WIDTH-1:0] b,
  output logic                           less
);
  localparam int WW = Extra + ELEMENT_WIDTH;

  logic [1:0]               exn_a, exn_b;
  logic [ELEMENT_WIDTH-2:0] mag_a, mag_b;
  logic                     unused_sign;

  assign exn_a       = a[WW-1 -: 2];
  assign exn_b       = b[WW-1 -: 2];
  assign mag_a       = a[ELEMENT_WIDTH-2:0];
  assign mag_b       = b[ELEMENT_WIDTH-2:0];
  assign unused_sign = a[ELEMENT_WIDTH-1] ^ b[ELEMENT_WIDTH-1];

  // Class rank first; the payload only matters between two normals.
  always_comb begin
    less = 1'b0;
    if (exn_a != exn_b)          less = (exn_a < exn_b);
    else if (exn_a == EXN_NORMAL) less = (mag_a < mag_b);
  end

endmodule

// File: rtl/error_calculation.sv
// Best-candidate tracker. Weight batches stream in one per clock against a
// free-running batch counter; on the last batch the live error is compared
// with the stored best and, if strictly smaller in magnitude, the assembled
// weight vector and error are latched. Outputs are pure registers.
module error_calculation
  import error_calculation_pkg::*;
#(
  parameter int ELEMENT_WIDTH         = 32,
  parameter int Extra                 = 2,
  parameter int Num_Unknowns          = 2,
  parameter int Num_Unknown_Per_Batch = 1
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [Extra+ELEMENT_WIDTH-1:0]                      current_err,
  input  logic [(Extra+ELEMENT_WIDTH)*Num_Unknown_Per_Batch-1:0] current_weights,
  output logic [(Extra+ELEMENT_WIDTH)*Num_Unknowns-1:0]       Best_weights,
  output logic [Extra+ELEMENT_WIDTH-1:0]                      Best_error
);
  localparam int WW  = Extra + ELEMENT_WIDTH;
  localparam int P   = Num_Unknown_Per_Batch;
  localparam int N   = Num_Unknowns;
  localparam int B   = N / P;
  localparam int BW  = WW * P;
  localparam int BCW = (B > 1) ? $clog2(B) : 1;
  localparam logic [BCW-1:0] BC_LAST = BCW'(B - 1);
  localparam logic [WW-1:0]  RST_ERR = WW'(POS_INF);

  logic [BCW-1:0]        bc;
  logic                  last;
  logic [B-1:0][BW-1:0]  wbuf;
  logic [WW*N-1:0]       cand;
  logic                  cur_less;
  logic                  upd;
  logic                  unused_slot;

  assign last = (bc == BC_LAST);

  // Free-running batch position, wraps after the last batch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      bc <= '0;
    else if (last) bc <= '0;
    else           bc <= bc + 1'b1;
  end

  // Every batch is parked in its slot; only slots 0..B-2 are read back,
  // the last slot is bypassed by the live input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wbuf     <= '0;
    else      wbuf[bc] <= current_weights;
  end

  assign unused_slot = ^wbuf[B-1];

  // Batch 0 lands in the most-significant slice of the candidate.
  for (genvar k = 0; k < B; k++) begin : g_asm
    if (k == B - 1) begin : g_live
      assign cand[BW*(B-1-k) +: BW] = current_weights;
    end else begin : g_buf
      assign cand[BW*(B-1-k) +: BW] = wbuf[k];
    end
  end

  fp_mag_less #(
    .ELEMENT_WIDTH (ELEMENT_WIDTH),
    .Extra         (Extra)
  ) u_cmp (
    .a    (current_err),
    .b    (Best_error),
    .less (cur_less)
  );

  // NaN is excluded explicitly so a NaN can never become the best.
  assign upd = last && (current_err[WW-1 -: 2] != EXN_NAN) && cur_less;

  // Strictly-better candidates replace the stored best; ties keep the old one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Best_error   <= RST_ERR;
      Best_weights <= '0;
    end else if (upd) begin
      Best_error   <= current_err;
      Best_weights <= cand;
    end
  end

endmodule

// File: tb/tb_error_calculation.sv
// Randomized + directed scoreboard bench for error_calculation.
// Two instances: default (N=2,P=1,B=2) and N=2,P=2 (B=1).
module tb_error_calculation;
  localparam int WW = 34;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [WW-1:0]   err1 = '0, err2 = '0;
  logic [WW-1:0]   w1 = '0;
  logic [2*WW-1:0] w2 = '0;
  logic [2*WW-1:0] bw1, bw2;
  logic [WW-1:0]   be1, be2;

  always #5 clk = ~clk;

  error_calculation #(.ELEMENT_WIDTH(32), .Extra(2), .Num_Unknowns(2),
                      .Num_Unknown_Per_Batch(1)) dut (
    .clk(clk), .rst(rst), .current_err(err1), .current_weights(w1),
    .Best_weights(bw1), .Best_error(be1));

  error_calculation #(.ELEMENT_WIDTH(32), .Extra(2), .Num_Unknowns(2),
                      .Num_Unknown_Per_Batch(2)) dut2 (
    .clk(clk), .rst(rst), .current_err(err2), .current_weights(w2),
    .Best_weights(bw2), .Best_error(be2));

  typedef struct {
    int              id;
    logic [2*WW-1:0] w;
    logic [WW-1:0]   e;
    string           tag;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: best-so-far per instance, and the pending batch 0.
  logic [2*WW-1:0] m_bw1, m_bw2;
  logic [WW-1:0]   m_be1, m_be2;
  logic [WW-1:0]   batch0;
  int              bc1;

  localparam logic [WW-1:0] INF_W = {2'b10, 32'h7F80_0000};
  localparam logic [WW-1:0] NAN_W = {2'b11, 32'h7FC0_0000};

  // Magnitude as an ordinal: class band, then |value| bits for normals.
  function automatic longint mkey(input logic [WW-1:0] e);
    case (e[33:32])
      2'b00:   return 0;
      2'b01:   return (longint'(1) << 32) + longint'(e[30:0]);
      2'b10:   return longint'(2) << 32;
      default: return longint'(3) << 32;
    endcase
  endfunction

  function automatic bit wins(input logic [WW-1:0] cand, input logic [WW-1:0] best);
    return (cand[33:32] != 2'b11) && (mkey(cand) < mkey(best));
  endfunction

  function automatic logic [WW-1:0] nrm(input logic [31:0] v);
    return {2'b01, v};
  endfunction

  function automatic logic [WW-1:0] rw();
    logic [1:0] x;
    x = 2'($urandom_range(0, 3));
    return {x, 32'($urandom)};
  endfunction

  function automatic logic [WW-1:0] re();
    int          k;
    logic [7:0]  ex;
    logic [22:0] fr;
    logic        sg;
    k  = $urandom_range(0, 9);
    ex = 8'($urandom_range(120, 130));
    fr = 23'($urandom_range(0, 3)) << 20;
    sg = 1'($urandom);
    if (k == 0)      return {2'b00, 32'($urandom)};
    else if (k <= 6) return {2'b01, sg, ex, fr};
    else if (k <= 8) return {2'b10, 32'($urandom)};
    else             return {2'b11, 32'($urandom)};
  endfunction

  // One clock of stimulus for both instances; model advances and the
  // expected post-edge outputs go into the scoreboard.
  task automatic step(input bit rel,
                      input logic [WW-1:0] a_w, input logic [WW-1:0] a_e,
                      input logic [2*WW-1:0] b_w, input logic [WW-1:0] b_e,
                      input string tag);
    @(negedge clk); #1;
    rst = rel; w1 = a_w; err1 = a_e; w2 = b_w; err2 = b_e;
    if (!rel) begin
      m_bw1 = '0; m_be1 = INF_W; m_bw2 = '0; m_be2 = INF_W; bc1 = 0;
    end else begin
      if (bc1 == 0) batch0 = a_w;
      else if (wins(a_e, m_be1)) begin
        m_bw1 = {batch0, a_w};
        m_be1 = a_e;
      end
      bc1 = (bc1 + 1) % 2;
      if (wins(b_e, m_be2)) begin
        m_bw2 = b_w;
        m_be2 = b_e;
      end
    end
    q.push_back('{0, m_bw1, m_be1, tag});
    q.push_back('{1, m_bw2, m_be2, tag});
  endtask

  // Monitor: each falling edge, compare everything issued before the last rising edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t x;
      logic [2*WW-1:0] aw;
      logic [WW-1:0]   ae;
      x  = q.pop_front();
      aw = (x.id == 0) ? bw1 : bw2;
      ae = (x.id == 0) ? be1 : be2;
      checks++;
      if (aw !== x.w || ae !== x.e) begin
        errors++;
        $display("FAIL %s dut%0d: got w=%h e=%h, want w=%h e=%h",
                 x.tag, x.id, aw, ae, x.w, x.e);
      end
    end
  end

  initial begin
    // Directed sequence on the B=2 instance; the P=2 instance sees NaN
    // errors meanwhile, so it must sit at its reset values.
    step(0, '0, '0, '0, '0, "reset");
    step(1, nrm(32'h40A7_5C29), '0, {rw(), rw()}, NAN_W, "first_b0");
    step(1, nrm(32'hBEA4_DD2F), nrm(32'hC000_0000), {rw(), rw()}, NAN_W, "first");
    step(1, nrm(32'hC09D_0E56), '0, {rw(), rw()}, NAN_W, "larger_b0");
    step(1, nrm(32'h0000_0000), nrm(32'h4040_0000), {rw(), rw()}, NAN_W, "larger");
    step(1, nrm(32'hC0A7_5C29), '0, {rw(), rw()}, NAN_W, "zero_b0");
    step(1, nrm(32'hBEA4_DD2F), {2'b00, 32'h3F07_AE14}, {rw(), rw()}, NAN_W, "zero_wins");
    step(1, rw(), '0, {rw(), rw()}, NAN_W, "tie_b0");
    step(1, rw(), {2'b00, 32'h0}, {rw(), rw()}, NAN_W, "tie");
    step(1, rw(), '0, {rw(), rw()}, NAN_W, "nan_b0");
    step(1, rw(), NAN_W, {rw(), rw()}, NAN_W, "nan");
    step(0, rw(), rw(), {rw(), rw()}, rw(), "reset2");
    // P=2 plan: two single-cycle candidates, the second is smaller.
    step(1, rw(), '0, {nrm(32'h40A7_5C29), {2'b00, 32'h0}}, nrm(32'hC000_0000), "p2_a");
    step(1, rw(), NAN_W, {{2'b00, 32'h0}, nrm(32'hBEA4_DD2F)}, nrm(32'h3F07_AE14), "p2_b");
    step(1, rw(), '0, {rw(), rw()}, nrm(32'h4040_0000), "p2_c");
    // Random rounds; odd length so the next reset lands mid-candidate.
    for (int r = 0; r < 6; r++) begin
      step(0, rw(), rw(), {rw(), rw()}, rw(), "rnd_rst");
      for (int i = 0; i < 15; i++)
        step(1, rw(), re(), {rw(), rw()}, re(), "rnd");
    end
    @(negedge clk); #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
